// File: rtl/nand_test_pkg.sv
// Shared definitions for the NAND sweep checker.
//   state_t     : sweep FSM states (IDLE, WAIT, CHECK, DONE)
//   nand_expect : golden NAND response for a vector of a given width
//   *_MIN/_MAX  : legal parameter ranges; SETTLE_W sizes the settle counter
package nand_test_pkg;

  localparam int unsigned WIDTH_MIN  = 1;
  localparam int unsigned WIDTH_MAX  = 8;
  localparam int unsigned SETTLE_MIN = 1;
  localparam int unsigned SETTLE_MAX = 15;
  localparam int unsigned SETTLE_W   = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } state_t;

  // NOT of the AND-reduction over the low 'width' bits of a.
  function automatic logic nand_expect(input logic [WIDTH_MAX-1:0] a,
                                       input int unsigned width);
    logic all_ones;
    all_ones = 1'b1;
    for (int unsigned i = 0; i < WIDTH_MAX; i++) begin
      if (i < width && !a[i]) all_ones = 1'b0;
    end
    return !all_ones;
  endfunction

endpackage

// File: rtl/nand_settle_timer.sv
// Settle-delay down-counter for the sweep checker.
//   clk, rst : clock and synchronous active-high reset
//   load     : load 'value' into the counter this cycle
//   value    : settle length in cycles
//   expire   : high in the last cycle of the settle window
module nand_settle_timer
  import nand_test_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic [SETTLE_W-1:0] value,
  output logic                expire
);

  logic [SETTLE_W-1:0] count;

  // Counts down to zero and parks there; a load of N yields expire in the
  // N-th cycle after the load edge.
  always_ff @(posedge clk) begin
    if (rst)                count <= '0;
    else if (load)          count <= value;
    else if (count != '0)   count <= count - 1'b1;
  end

  assign expire = (count == SETTLE_W'(1));

endmodule

// File: rtl/nand_sweep_checker.sv
// Exhaustive NAND gate sweep checker: drives every WIDTH-bit vector on A,
// waits SETTLE cycles, samples Y and compares against the NAND of A.
//   clk, rst         : clock, synchronous active-high reset
//   start            : one-cycle sweep request (accepted only in IDLE)
//   A                : stimulus vector to the network under test
//   Y                : response from the network under test
//   busy, done       : sweep in progress / one-cycle end-of-sweep pulse
//   pass             : last completed sweep had zero mismatches
//   err_count        : saturating mismatch count
//   first_fail(_valid): first mismatching vector of the sweep
module nand_sweep_checker
  import nand_test_pkg::*;
#(
  parameter int unsigned WIDTH  = 2,
  parameter int unsigned SETTLE = 1,
  parameter int unsigned ERRW   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic [WIDTH-1:0] A,
  input  logic             Y,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERRW-1:0]  err_count,
  output logic [WIDTH-1:0] first_fail,
  output logic             first_fail_valid
);

  state_t               state, state_next;
  logic                 load;
  logic                 expire;
  logic                 last_vec;
  logic                 mismatch;
  logic                 mismatch_seen;
  logic [WIDTH_MAX-1:0] a_ext;

  nand_settle_timer u_timer (
    .clk    (clk),
    .rst    (rst),
    .load   (load),
    .value  (SETTLE_W'(SETTLE)),
    .expire (expire)
  );

  always_comb begin
    a_ext            = '0;
    a_ext[WIDTH-1:0] = A;
  end

  assign last_vec = &A;
  assign mismatch = (state == CHECK) && (Y != nand_expect(a_ext, WIDTH));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    load       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load       = 1'b1;
          state_next = WAIT;
        end
      end
      WAIT: begin
        if (expire) state_next = CHECK;
      end
      CHECK: begin
        if (last_vec) begin
          state_next = DONE;
        end else begin
          load       = 1'b1;
          state_next = WAIT;
        end
      end
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign busy = (state == WAIT) || (state == CHECK);
  assign done = (state == DONE);

  // pass is driven from mismatch_seen, not err_count, so a saturated
  // counter cannot wrap into a false pass.
  always_ff @(posedge clk) begin
    if (rst) begin
      A                <= '0;
      err_count        <= '0;
      first_fail       <= '0;
      first_fail_valid <= 1'b0;
      mismatch_seen    <= 1'b0;
      pass             <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            A                <= '0;
            err_count        <= '0;
            first_fail_valid <= 1'b0;
            mismatch_seen    <= 1'b0;
          end
        end
        CHECK: begin
          if (mismatch) begin
            mismatch_seen <= 1'b1;
            if (err_count != '1) err_count <= err_count + 1'b1;
            if (!first_fail_valid) begin
              first_fail       <= A;
              first_fail_valid <= 1'b1;
            end
          end
          if (!last_vec) A <= A + 1'b1;
        end
        DONE: pass <= !mismatch_seen;
        default: ;
      endcase
    end
  end

endmodule
